// File: rtl/stage_four.sv
`default_nettype none
// ============================================================================
//  Module   : stage_four
//  Purpose  : Writeback stage. Latches memory-stage results into the MEM/WB
//             register and drives the register-file write port. A 32-bit
//             result with r0_en set needs two writes: the low word to rd and
//             the high word to R0. In the default build these take two cycles
//             (WR_LO then WR_HI), and upstream is stalled for the first one.
//             The stage also counts retired instructions.
//  Optional : `define WB_DUAL_PORT_EN adds a second write port
//             (rf_wr2_*). The R0 write then issues in the same cycle as the
//             rd write, and the stage never stalls.
//  Ports    : clk, rst (sync, active-high), halt_sys (freeze all state)
//             in_valid/instruction/data/r0_en/reg_wr - memory stage outputs
//             stall                 - upstream must hold this cycle
//             rf_wr_en/addr/data    - register-file write port
//             rf_wr2_en/addr/data   - second write port (optional build)
//             instruction_out       - instruction in writeback (0 if bubble)
//             retired               - retired-instruction counter (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module stage_four #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int RD_LSB  = 8,
  parameter int R0_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt_sys,
  input  logic                in_valid,
  input  logic [15:0]         instruction,
  input  logic [2*DATA_W-1:0] data,
  input  logic                r0_en,
  input  logic                reg_wr,
  output logic                stall,
  output logic                rf_wr_en,
  output logic [ADDR_W-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
`ifdef WB_DUAL_PORT_EN
  output logic                rf_wr2_en,
  output logic [ADDR_W-1:0]   rf_wr2_addr,
  output logic [DATA_W-1:0]   rf_wr2_data,
`endif
  output logic [15:0]         instruction_out,
  output logic [15:0]         retired
);

  localparam logic [ADDR_W-1:0] C_R0 = ADDR_W'(R0_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t                state_q,   state_d;
  logic                  valid_q,   valid_d;
  logic [15:0]           instr_q,   instr_d;
  logic [2*DATA_W-1:0]   data_q,    data_d;
  logic                  r0_en_q,   r0_en_d;
  logic                  reg_wr_q,  reg_wr_d;
  logic [15:0]           retired_q, retired_d;

  logic [ADDR_W-1:0]     w_rd;
  logic                  w_retire;
  logic                  w_capture;

  assign w_rd = instr_q[RD_LSB+ADDR_W-1:RD_LSB];

`ifdef WB_DUAL_PORT_EN
  assign stall = 1'b0;
`else
  // Stall only for the first half of a dual write. It is derived from frozen
  // state, so it holds its value while halt_sys is high.
  assign stall = (state_q == WR_LO) && r0_en_q;
`endif

  assign w_capture = !halt_sys && !stall;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    data_d    = data_q;
    r0_en_d   = r0_en_q;
    reg_wr_d  = reg_wr_q;
    w_retire  = 1'b0;

    if (!halt_sys) begin
      case (state_q)
        WR_LO: begin
`ifdef WB_DUAL_PORT_EN
          w_retire = 1'b1;
`else
          if (r0_en_q) state_d = WR_HI;
          else         w_retire = 1'b1;
`endif
        end
        WR_HI:   w_retire = 1'b1;
        default: ;
      endcase
    end

    // A capture means the current instruction is finished, so the next state
    // follows whatever has just been latched.
    if (w_capture) begin
      valid_d  = in_valid;
      instr_d  = instruction;
      data_d   = data;
      r0_en_d  = r0_en;
      reg_wr_d = reg_wr;
      state_d  = in_valid ? WR_LO : IDLE;
    end

    retired_d = retired_q + 16'(w_retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      data_q    <= '0;
      r0_en_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      data_q    <= data_d;
      r0_en_q   <= r0_en_d;
      reg_wr_q  <= reg_wr_d;
      retired_q <= retired_d;
    end
  end

  // Write port. Address and data are zeroed when idle so that nothing stale
  // from a latched bubble leaks onto the port.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    case (state_q)
      WR_LO: begin
`ifdef WB_DUAL_PORT_EN
        // rd == R0 with a high word pending: port 2 carries the final value.
        rf_wr_en = reg_wr_q && !(r0_en_q && (w_rd == C_R0));
`else
        rf_wr_en = reg_wr_q;
`endif
        rf_wr_addr = w_rd;
        rf_wr_data = data_q[DATA_W-1:0];
      end
      WR_HI: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = C_R0;
        rf_wr_data = data_q[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
    if (halt_sys) rf_wr_en = 1'b0;
  end

`ifdef WB_DUAL_PORT_EN
  assign rf_wr2_en   = (state_q == WR_LO) && r0_en_q && !halt_sys;
  assign rf_wr2_addr = (state_q == WR_LO) ? C_R0 : '0;
  assign rf_wr2_data = (state_q == WR_LO) ? data_q[2*DATA_W-1:DATA_W] : '0;
`endif

  assign instruction_out = valid_q ? instr_q : 16'h0000;
  assign retired         = retired_q;

endmodule
`default_nettype wire
